pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline-stage register, the next generation of the fixed IF/ID register.
- Generic DATA_W payload, valid/ready handshake on both sides, a 2-entry skid buffer so in_ready is registered, external stall, and synchronous flush.
- Flush and reset load a bubble value; the default is a NOP in the low 32 bits.
- Instantiated between any two pipeline stages: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- DATA_W, 96, payload width (PC + PCPlus4 + Instr).
- BUBBLE_VAL, {64'h0, 32'h00000013}, payload loaded on reset/flush (addi x0,x0,0 in the low word).
- CNT_W, 16, width of the optional event counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds valid payload.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main-entry payload.
- stall  in  1  hazard-unit hold; acts as out_ready=0.
- flush  in  1  synchronous kill of all held entries.
- stall_cnt  out  CNT_W  only with PIPE_STAGE_CNT_EN.
- flush_cnt  out  CNT_W  only with PIPE_STAGE_CNT_EN.

Behaviour:
- Storage: main entry M (m_valid, m_data) and skid entry S (s_valid, s_data).
- Handshake terms:
  - out_data = m_data; out_valid = m_valid.
  - in_ready = ~s_valid, taken straight from a flop; no combinational path from out_ready/stall to in_ready.
  - accept = in_valid & in_ready.
  - drain = m_valid & out_ready & ~stall.
- States, derived from {m_valid, s_valid}:
  - EMPTY (0,0): accept -> ONE, M<=in_data.
  - ONE (1,0): accept & drain -> ONE, M<=in_data. accept & ~drain -> FULL, S<=in_data. ~accept & drain -> EMPTY. Otherwise hold.
  - FULL (1,1): in_ready=0. drain -> ONE, M<=S. Otherwise hold.
- Latency and throughput: 1 cycle from in fire to out_valid; 1 transfer/cycle sustained when out_ready=1 and stall=0.
- Ordering: strict FIFO. S always holds the item younger than M.
- Hold rules: held payload is stable while out_valid=1 and not drained. After a drain with no refill, m_data keeps its last value; only reset/flush load BUBBLE_VAL.
- flush=1 at a clock edge:
  - m_valid<=0, s_valid<=0, m_data<=BUBBLE_VAL, s_data<=BUBBLE_VAL.
  - Input presented that cycle is discarded, even though in_ready may be 1.
  - Priority: flush > stall > accept/drain. Flush together with stall still clears.
- Reset (asynchronous, any time including mid-transfer): both valids 0, both data regs = BUBBLE_VAL, in_ready=1 on the first edge after release, counters 0.
- Boundaries:
  - stall=1 with out_ready=1 behaves exactly as out_ready=0.
  - FULL with stall held keeps both entries indefinitely.
  - in_valid while FULL is ignored; upstream must hold its data.

Optional Feature:
- Macro: PIPE_STAGE_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with m_valid & ~(out_ready & ~stall).
  - flush_cnt increments each cycle flush=1.
  - Both saturate at all-ones, clear on reset, and are not cleared by flush.
- Undefined: both ports and their logic are absent; remaining behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum pipe_state_e {EMPTY, ONE, FULL};
  - localparam RV_NOP = 32'h00000013;
  - default widths XLEN=32, IFID_W=96.
- One sub-module, sat_counter (CNT_W, inc, clk, reset -> count), instantiated twice under PIPE_STAGE_CNT_EN.

Test Plan:
1. Reset held 12 ns with in_valid=1, in_data=...AABBCCDD. Required: out_valid=0, out_data=BUBBLE_VAL, in_ready=1. After release, ...AABBCCDD appears with out_valid=1 one cycle later.
2. Stream 3 words (...11112222, ...33334444, ...55556666), out_ready=1, stall=0. Required: each word appears on out_data one cycle after its input, back-to-back, no gaps.
3. ONE state holding ...11112222; assert stall 2 cycles while presenting ...DEADBEEF. Required:
   - FULL after the first edge; in_ready=0.
   - out_data stays ...11112222.
   - After stall drops, ...11112222 then ...DEADBEEF drain in order.
4. FULL state plus flush=1 with stall=1 and in_valid=1 (...87654321). Required: next cycle out_valid=0, out_data low word=00000013, in_ready=1, ...87654321 lost.
5. Assert reset asynchronously mid-cycle while FULL. Required: out_valid and the internal s_valid drop immediately, without waiting for a clock edge; in_ready=1 after release.
6. With PIPE_STAGE_CNT_EN and CNT_W=4: hold stall for 20 cycles while valid. Required: stall_cnt saturates at 4'hF. One flush cycle gives flush_cnt=1, with stall_cnt unchanged by the flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage registers.
`timescale 1ns/1ps
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int IFID_W = 96;

   // addi x0,x0,0
   localparam logic [31:0] RV_NOP = 32'h00000013;

   // Encoding mirrors {m_valid, s_valid}.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
`timescale 1ns/1ps
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, stall and flush.
// Optional event counters are built when PIPE_STAGE_CNT_EN is defined.
//
// state | meaning
// EMPTY | no valid entry; in_ready=1
// ONE   | main entry valid, skid empty; in_ready=1
// FULL  | main and skid valid; skid holds the younger item; in_ready=0
`timescale 1ns/1ps
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = IFID_W,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(RV_NOP),
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush
`ifdef PIPE_STAGE_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   pipe_state_e       state;
   logic              m_valid;
   logic              s_valid;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] s_data;

   logic accept;
   logic drain;

   assign accept    = in_valid & in_ready;
   assign drain     = m_valid & out_ready & ~stall;
   assign out_valid = m_valid;
   assign out_data  = m_data;

   // in_ready is its own flop (always equal to ~s_valid) so it has no
   // combinational dependence on out_ready or stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= EMPTY;
         m_valid  <= 1'b0;
         s_valid  <= 1'b0;
         in_ready <= 1'b1;
         m_data   <= BUBBLE_VAL;
         s_data   <= BUBBLE_VAL;
      end else if (flush) begin
         state    <= EMPTY;
         m_valid  <= 1'b0;
         s_valid  <= 1'b0;
         in_ready <= 1'b1;
         m_data   <= BUBBLE_VAL;
         s_data   <= BUBBLE_VAL;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state   <= ONE;
                  m_valid <= 1'b1;
                  m_data  <= in_data;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  m_data <= in_data;
               end else if (accept) begin
                  state    <= FULL;
                  s_valid  <= 1'b1;
                  in_ready <= 1'b0;
                  s_data   <= in_data;
               end else if (drain) begin
                  state   <= EMPTY;
                  m_valid <= 1'b0;
               end
            end
            FULL: begin
               if (drain) begin
                  state    <= ONE;
                  s_valid  <= 1'b0;
                  in_ready <= 1'b1;
                  m_data   <= s_data;
               end
            end
            default: begin
               state    <= EMPTY;
               m_valid  <= 1'b0;
               s_valid  <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_CNT_EN
   logic stall_inc;

   // Counts cycles where a valid entry is presented but not taken.
   assign stall_inc = m_valid & ~(out_ready & ~stall);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int DATA_W = IFID_W;
   localparam int CNT_W  = 4;
   localparam logic [DATA_W-1:0] BUBBLE = {64'h0, 32'h00000013};

   localparam logic [DATA_W-1:0] W1  = 96'h0101_0101_0A0A_0A0A_1111_2222;
   localparam logic [DATA_W-1:0] W2  = 96'h0202_0202_0B0B_0B0B_3333_4444;
   localparam logic [DATA_W-1:0] W3  = 96'h0303_0303_0C0C_0C0C_5555_6666;
   localparam logic [DATA_W-1:0] WD  = 96'h0404_0404_0D0D_0D0D_DEAD_BEEF;
   localparam logic [DATA_W-1:0] WF  = 96'h0505_0505_0E0E_0E0E_8765_4321;
   localparam logic [DATA_W-1:0] WA  = 96'h0606_0606_0F0F_0F0F_AABB_CCDD;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              stall;
   logic              flush;
`ifdef PIPE_STAGE_CNT_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall     (stall),
      .flush     (flush)
`ifdef PIPE_STAGE_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      #7 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic              iv;
      logic [DATA_W-1:0] id;
      logic              ordy;
      logic              stl;
      logic              fl;
      logic              e_ov;
      logic [DATA_W-1:0] e_od;
      logic              e_ir;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, logic [DATA_W-1:0] id, logic ordy,
                               logic stl, logic fl, logic e_ov,
                               logic [DATA_W-1:0] e_od, logic e_ir);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.stl = stl; v.fl = fl;
      v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
      return v;
   endfunction

   // Reference model: a FIFO of at most two items plus the last head value.
   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] m_last;
   int                m_stall_cnt;
   int                m_flush_cnt;

   task automatic model_reset();
      mq.delete();
      m_last      = BUBBLE;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endtask

   task automatic model_edge();
      bit acc;
      bit drn;
      if ((mq.size() > 0) && !(out_ready && !stall) && m_stall_cnt < 15)
         m_stall_cnt++;
      if (flush && m_flush_cnt < 15)
         m_flush_cnt++;
      if (flush) begin
         mq.delete();
         m_last = BUBBLE;
      end else begin
         acc = in_valid && (mq.size() < 2);
         drn = (mq.size() > 0) && out_ready && !stall;
         if (drn) m_last = mq.pop_front();
         if (acc) mq.push_back(in_data);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();

      // Reset held with input presented
      in_valid = 1'b1;
      in_data  = WA;
      #8;
      check("rst_out_valid", DATA_W'(out_valid), DATA_W'(1'b0));
      check("rst_out_data", out_data, BUBBLE);
      check("rst_in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
      #4 reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_valid", DATA_W'(out_valid), DATA_W'(1'b1));
      check("post_rst_data", out_data, WA);

      // Directed table: stream, stall into FULL, flush with stall
      do_reset();
      tbl.push_back(mk(1, W1, 1, 0, 0, 1, W1, 1));
      tbl.push_back(mk(1, W2, 1, 0, 0, 1, W2, 1));
      tbl.push_back(mk(1, W3, 1, 0, 0, 1, W3, 1));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, W3, 1));
      tbl.push_back(mk(1, W1, 1, 0, 0, 1, W1, 1));
      tbl.push_back(mk(1, WD, 1, 1, 0, 1, W1, 0));
      tbl.push_back(mk(1, WD, 1, 1, 0, 1, W1, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 1, WD, 1));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, WD, 1));
      tbl.push_back(mk(1, W2, 0, 0, 0, 1, W2, 1));
      tbl.push_back(mk(1, W3, 0, 0, 0, 1, W2, 0));
      tbl.push_back(mk(1, WF, 1, 1, 1, 0, BUBBLE, 1));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, BUBBLE, 1));
      tbl.push_back(mk(1, W1, 1, 0, 1, 0, BUBBLE, 1));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, BUBBLE, 1));
      foreach (tbl[i]) begin
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].id;
         out_ready = tbl[i].ordy;
         stall     = tbl[i].stl;
         flush     = tbl[i].fl;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_out_valid", i), DATA_W'(out_valid), DATA_W'(tbl[i].e_ov));
         check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
         check($sformatf("tbl%0d_in_ready", i), DATA_W'(in_ready), DATA_W'(tbl[i].e_ir));
      end

      // Asynchronous reset mid-cycle while FULL
      do_reset();
      in_valid = 1'b1; in_data = W1;
      @(posedge clk); #1;
      in_data = W2;
      @(posedge clk); #1;
      check("full_in_ready", DATA_W'(in_ready), DATA_W'(1'b0));
      idle_inputs();
      #2 reset = 1'b1;
      #1;
      check("async_out_valid", DATA_W'(out_valid), DATA_W'(1'b0));
      check("async_s_valid", DATA_W'(dut.s_valid), DATA_W'(1'b0));
      check("async_out_data", out_data, BUBBLE);
      #3 reset = 1'b0;
      @(posedge clk); #1;
      check("async_in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
      check("async_stays_empty", DATA_W'(out_valid), DATA_W'(1'b0));

`ifdef PIPE_STAGE_CNT_EN
      // Counter saturation and flush counting
      do_reset();
      in_valid = 1'b1; in_data = W1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (c == 4) check("stall_cnt_5", DATA_W'(stall_cnt), DATA_W'(4'd5));
      end
      check("stall_cnt_sat", DATA_W'(stall_cnt), DATA_W'(4'hF));
      check("flush_cnt_0", DATA_W'(flush_cnt), DATA_W'(4'd0));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; stall = 1'b0;
      check("flush_cnt_1", DATA_W'(flush_cnt), DATA_W'(4'd1));
      check("stall_cnt_kept", DATA_W'(stall_cnt), DATA_W'(4'hF));
      @(posedge clk); #1;
      check("flush_cnt_hold", DATA_W'(flush_cnt), DATA_W'(4'd1));
`endif

      // Randomized traffic against the queue model
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = {$urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 9) < 6);
         stall     = ($urandom_range(0, 9) < 2);
         flush     = ($urandom_range(0, 39) == 0);
         @(posedge clk);
         model_edge();
         #1;
         check("rnd_out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
         check("rnd_out_data", out_data, (mq.size() > 0) ? mq[0] : m_last);
         check("rnd_in_ready", DATA_W'(in_ready), DATA_W'(mq.size() < 2));
`ifdef PIPE_STAGE_CNT_EN
         check("rnd_stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall_cnt));
         check("rnd_flush_cnt", DATA_W'(flush_cnt), DATA_W'(m_flush_cnt));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
